pmu_snapshot_reader: RTL and testbench
======================================

PMU_SNAPSHOT_READER -- requirements
Module: pmu_snapshot_reader

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- DATA_WIDTH, 64, counter data width.
- TILE_COUNT, 1, number of tiles swept.
- EVENT_SIGNAL_COUNT, 23, counters per tile; registers per tile = EVENT_SIGNAL_COUNT+1, including config register 0.
- ADDR_REG_WIDTH, 6, register index width.
- ADDR_TILE_WIDTH, 7, tile index width.
- ADDR_ALIGN_WIDTH, 3, 64-bit alignment bits.
- TIMEOUT_CYCLES, 1024, request timeout in noc_clk cycles.
- AW = ADDR_TILE_WIDTH+ADDR_REG_WIDTH+ADDR_ALIGN_WIDTH (derived).

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- noc_clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-low reset.
- start_i, in, 1, single-cycle pulse requesting one sweep.
- period_i, in, 32, auto-sweep period in cycles; 0 disables.
- busy_o, out, 1, sweep in progress.
- counter_read_enable_o, out, 1, read request level to the counter domain.
- counter_read_address_o, out, AW, read address.
- counter_read_valid_i, in, 1, responder valid level; asynchronous to noc_clk.
- counter_read_data_i, in, DATA_WIDTH, responder data.
- sample_valid_o, out, 1, output sample valid.
- sample_ready_i, in, 1, output sample ready.
- sample_data_o, out, DATA_WIDTH, counter value.
- sample_tile_o, out, ADDR_TILE_WIDTH, tile index of sample.
- sample_reg_o, out, ADDR_REG_WIDTH, register index of sample.
- sample_last_o, out, 1, final sample of the sweep.
- sample_err_o, out, 1, sample produced by timeout.
- sweep_count_o, out, 16, completed sweeps; wraps modulo 2^16.

Function
REQ-003 The block SHALL sync counter_read_valid_i through a 2-flop synchronizer (vld_s) before any use.
REQ-004 The FSM SHALL have states IDLE, REQ, RELEASE, EMIT.
REQ-005 IDLE->REQ SHALL occur when pending is set. Pending is cleared on the transition. Index is (tile 0, reg 0).
REQ-006 counter_read_address_o SHALL equal {tile, reg, ADDR_ALIGN_WIDTH'b0}. It is registered and stable from REQ entry until RELEASE exit.
REQ-007 In REQ, counter_read_enable_o SHALL be 1.
REQ-008 In REQ, on vld_s=1 the block SHALL capture counter_read_data_i into the sample register, clear err, and go to RELEASE.
REQ-009 A REQ timeout counter SHALL start at 0 on REQ entry. When it reaches TIMEOUT_CYCLES-1 without vld_s, the block SHALL load all-ones data, set err=1, and go to RELEASE.
REQ-010 In RELEASE, counter_read_enable_o SHALL be 0. The FSM SHALL go to EMIT when vld_s=0, or immediately if entered by timeout.
REQ-011 In EMIT, sample_valid_o SHALL be 1 and all sample_* outputs SHALL be held stable until sample_valid_o && sample_ready_i.
REQ-012 On the EMIT handshake, if not last, the index SHALL advance (reg+1; at reg=EVENT_SIGNAL_COUNT wrap to 0 and tile+1) and the FSM go to REQ. If last, sweep_count_o SHALL increment and the FSM go to IDLE.
REQ-013 sample_last_o SHALL be 1 iff tile=TILE_COUNT-1 and reg=EVENT_SIGNAL_COUNT.
REQ-014 busy_o SHALL be 1 in every state except IDLE.
REQ-015 The period counter SHALL:
- run while period_i!=0;
- on reaching period_i-1, reload to 0 and set pending;
- be cleared whenever period_i changes or equals 0.
REQ-016 start_i SHALL set pending in any state. Multiple requests while pending SHALL coalesce into one. A request during a sweep SHALL produce exactly one following sweep.
REQ-017 When start_i and an IDLE->REQ transition coincide, pending SHALL remain set.
REQ-018 Sweep latency SHALL be unbounded only through sample_ready_i backpressure; each read is bounded by TIMEOUT_CYCLES plus synchronizer delay.

Reset
REQ-019 While rst=0, the block SHALL force the following, asynchronously:
- FSM=IDLE, pending=0;
- period counter, timeout counter, tile, reg = 0;
- counter_read_enable_o=0, counter_read_address_o=0;
- sample_valid_o=0, sample_data_o=0, sample_tile_o=0, sample_reg_o=0, sample_last_o=0, sample_err_o=0;
- busy_o=0, sweep_count_o=0.
REQ-020 Reset deassertion mid-sweep SHALL resume in IDLE with no sample emitted. The responder sees enable drop to 0.

Verification
REQ-021 TILE_COUNT=2, EVENT_SIGNAL_COUNT=3, responder returns address as data, sample_ready_i=1, start_i pulse -> 8 samples with addresses 0x000,0x008,...,0x018,0x200,...,0x218 in order; only the 8th has last=1; sweep_count_o=1; busy_o=0 afterwards.
REQ-022 Responder never asserts valid -> after TIMEOUT_CYCLES cycles, sample data=all-ones, err=1; the sweep continues to the next register.
REQ-023 sample_ready_i held 0 for 50 cycles during EMIT -> sample_* outputs stable; counter_read_enable_o stays 0; no new request issued.
REQ-024 Three start_i pulses during one sweep -> exactly two sweeps total; sweep_count_o=2.
REQ-025 period_i=200 with a fast responder -> sweeps begin every 200 cycles. With period_i shorter than sweep time, sweeps run back-to-back with no lost or duplicated sweeps beyond coalescing.
REQ-026 rst asserted while in REQ -> counter_read_enable_o=0 and sample_valid_o=0 in the same cycle; after release, state is IDLE and sweep_count_o=0.

Source files
------------

// File: rtl/pmu_snapshot_reader.sv
// PMU snapshot reader: sweeps tile/register counters over a
// level-handshake read port and streams them out as samples.
module pmu_snapshot_reader #(
  parameter int DATA_WIDTH         = 64,
  parameter int TILE_COUNT         = 1,
  parameter int EVENT_SIGNAL_COUNT = 23,
  parameter int ADDR_REG_WIDTH     = 6,
  parameter int ADDR_TILE_WIDTH    = 7,
  parameter int ADDR_ALIGN_WIDTH   = 3,
  parameter int TIMEOUT_CYCLES     = 1024,
  parameter int AW = ADDR_TILE_WIDTH + ADDR_REG_WIDTH
                     + ADDR_ALIGN_WIDTH
) (
  input  logic                       noc_clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [31:0]                period_i,
  output logic                       busy_o,
  output logic                       counter_read_enable_o,
  output logic [AW-1:0]              counter_read_address_o,
  input  logic                       counter_read_valid_i,
  input  logic [DATA_WIDTH-1:0]      counter_read_data_i,
  output logic                       sample_valid_o,
  input  logic                       sample_ready_i,
  output logic [DATA_WIDTH-1:0]      sample_data_o,
  output logic [ADDR_TILE_WIDTH-1:0] sample_tile_o,
  output logic [ADDR_REG_WIDTH-1:0]  sample_reg_o,
  output logic                       sample_last_o,
  output logic                       sample_err_o,
  output logic [15:0]                sweep_count_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE,
    EMIT
  } state_t;

  state_t                     state_q;
  logic                       pend_q;
  logic                       vld_meta_q;
  logic                       vld_s_q;
  logic [31:0]                per_cnt_q;
  logic [31:0]                per_prev_q;
  logic [TW-1:0]              to_cnt_q;
  logic                       to_flag_q;
  logic [ADDR_TILE_WIDTH-1:0] tile_q;
  logic [ADDR_REG_WIDTH-1:0]  reg_q;
  logic                       en_q;
  logic [AW-1:0]              addr_q;
  logic                       busy_q;
  logic                       svalid_q;
  logic [DATA_WIDTH-1:0]      sdata_q;
  logic [ADDR_TILE_WIDTH-1:0] stile_q;
  logic [ADDR_REG_WIDTH-1:0]  sreg_q;
  logic                       slast_q;
  logic                       serr_q;
  logic [15:0]                sweeps_q;

  logic                       per_tick;
  logic                       reg_wrap;
  logic                       is_last;
  logic [ADDR_TILE_WIDTH-1:0] tile_d;
  logic [ADDR_REG_WIDTH-1:0]  reg_d;

  assign per_tick = (period_i != 32'd0)
                 && (period_i == per_prev_q)
                 && (per_cnt_q == period_i - 32'd1);

  assign reg_wrap = reg_q == ADDR_REG_WIDTH'(EVENT_SIGNAL_COUNT);
  assign is_last  = reg_wrap
                 && (tile_q == ADDR_TILE_WIDTH'(TILE_COUNT - 1));
  assign tile_d   = reg_wrap ? tile_q + ADDR_TILE_WIDTH'(1) : tile_q;
  assign reg_d    = reg_wrap ? '0 : reg_q + ADDR_REG_WIDTH'(1);

  // Two-flop synchronizer for the responder valid level
  always_ff @(posedge noc_clk or negedge rst) begin
    if (!rst) begin
      vld_meta_q <= 1'b0;
      vld_s_q    <= 1'b0;
    end else begin
      vld_meta_q <= counter_read_valid_i;
      vld_s_q    <= vld_meta_q;
    end
  end

  // Auto-sweep period counter; restarts whenever the period changes
  always_ff @(posedge noc_clk or negedge rst) begin
    if (!rst) begin
      per_cnt_q  <= '0;
      per_prev_q <= '0;
    end else begin
      per_prev_q <= period_i;
      if (period_i == 32'd0 || period_i != per_prev_q)
        per_cnt_q <= '0;
      else if (per_tick)
        per_cnt_q <= '0;
      else
        per_cnt_q <= per_cnt_q + 32'd1;
    end
  end

  // Sweep FSM with registered outputs and coalescing pending flag
  always_ff @(posedge noc_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
      tile_q    <= '0;
      reg_q     <= '0;
      en_q      <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      svalid_q  <= 1'b0;
      sdata_q   <= '0;
      stile_q   <= '0;
      sreg_q    <= '0;
      slast_q   <= 1'b0;
      serr_q    <= 1'b0;
      sweeps_q  <= '0;
    end else begin
      pend_q <= pend_q | start_i | per_tick;
      unique case (state_q)
        IDLE: begin
          if (pend_q) begin
            pend_q   <= start_i | per_tick;
            state_q  <= REQ;
            tile_q   <= '0;
            reg_q    <= '0;
            addr_q   <= '0;
            en_q     <= 1'b1;
            to_cnt_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        REQ: begin
          if (vld_s_q) begin
            sdata_q   <= counter_read_data_i;
            serr_q    <= 1'b0;
            to_flag_q <= 1'b0;
            stile_q   <= tile_q;
            sreg_q    <= reg_q;
            slast_q   <= is_last;
            en_q      <= 1'b0;
            state_q   <= RELEASE;
          end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            sdata_q   <= '1;
            serr_q    <= 1'b1;
            to_flag_q <= 1'b1;
            stile_q   <= tile_q;
            sreg_q    <= reg_q;
            slast_q   <= is_last;
            en_q      <= 1'b0;
            state_q   <= RELEASE;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        RELEASE: begin
          if (to_flag_q || !vld_s_q) begin
            svalid_q <= 1'b1;
            state_q  <= EMIT;
          end
        end
        EMIT: begin
          if (sample_ready_i) begin
            svalid_q <= 1'b0;
            if (slast_q) begin
              sweeps_q <= sweeps_q + 16'd1;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end else begin
              tile_q   <= tile_d;
              reg_q    <= reg_d;
              addr_q   <= {tile_d, reg_d,
                           {ADDR_ALIGN_WIDTH{1'b0}}};
              en_q     <= 1'b1;
              to_cnt_q <= '0;
              state_q  <= REQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o                 = busy_q;
  assign counter_read_enable_o  = en_q;
  assign counter_read_address_o = addr_q;
  assign sample_valid_o         = svalid_q;
  assign sample_data_o          = sdata_q;
  assign sample_tile_o          = stile_q;
  assign sample_reg_o           = sreg_q;
  assign sample_last_o          = slast_q;
  assign sample_err_o           = serr_q;
  assign sweep_count_o          = sweeps_q;

endmodule

// File: tb/tb_pmu_snapshot_reader.sv
// Bench for pmu_snapshot_reader: 2 tiles x 4 registers,
// address-echo responder, scoreboard of expected samples.
module tb_pmu_snapshot_reader;

  localparam int DW = 64;
  localparam int TC = 2;
  localparam int EC = 3;
  localparam int RW = 6;
  localparam int TLW = 7;
  localparam int ALW = 3;
  localparam int TO = 16;
  localparam int AW = TLW + RW + ALW;

  logic           noc_clk = 1'b0;
  logic           rst = 1'b0;
  logic           start_i = 1'b0;
  logic [31:0]    period_i = '0;
  logic           busy_o;
  logic           counter_read_enable_o;
  logic [AW-1:0]  counter_read_address_o;
  logic           counter_read_valid_i = 1'b0;
  logic [DW-1:0]  counter_read_data_i = '0;
  logic           sample_valid_o;
  logic           sample_ready_i = 1'b1;
  logic [DW-1:0]  sample_data_o;
  logic [TLW-1:0] sample_tile_o;
  logic [RW-1:0]  sample_reg_o;
  logic           sample_last_o;
  logic           sample_err_o;
  logic [15:0]    sweep_count_o;

  pmu_snapshot_reader #(
    .DATA_WIDTH(DW), .TILE_COUNT(TC), .EVENT_SIGNAL_COUNT(EC),
    .ADDR_REG_WIDTH(RW), .ADDR_TILE_WIDTH(TLW),
    .ADDR_ALIGN_WIDTH(ALW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .noc_clk(noc_clk), .rst(rst), .start_i(start_i),
    .period_i(period_i), .busy_o(busy_o),
    .counter_read_enable_o(counter_read_enable_o),
    .counter_read_address_o(counter_read_address_o),
    .counter_read_valid_i(counter_read_valid_i),
    .counter_read_data_i(counter_read_data_i),
    .sample_valid_o(sample_valid_o),
    .sample_ready_i(sample_ready_i),
    .sample_data_o(sample_data_o),
    .sample_tile_o(sample_tile_o),
    .sample_reg_o(sample_reg_o),
    .sample_last_o(sample_last_o),
    .sample_err_o(sample_err_o),
    .sweep_count_o(sweep_count_o)
  );

  always #5 noc_clk = ~noc_clk;

  typedef struct {
    logic [DW-1:0]  data;
    logic [TLW-1:0] tile;
    logic [RW-1:0]  rg;
    logic           last;
    logic           err;
  } exp_t;

  exp_t  sb[$];
  int    rise_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  logic [AW-1:0] skip_addr = '1;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_sweep(logic [AW-1:0] skip);
    exp_t e;
    logic [AW-1:0] a;
    for (int t = 0; t < TC; t++) begin
      for (int r = 0; r <= EC; r++) begin
        a = {TLW'(t), RW'(r), {ALW{1'b0}}};
        e.tile = TLW'(t);
        e.rg   = RW'(r);
        e.last = (t == TC - 1) && (r == EC);
        e.err  = (a == skip);
        e.data = e.err ? '1 : DW'(a);
        sb.push_back(e);
      end
    end
  endtask

  always @(posedge noc_clk) cyc++;

  // Responder: echoes address as data a few cycles after enable
  int dly = 0;
  always @(posedge noc_clk) begin
    #1;
    if (!counter_read_enable_o) begin
      counter_read_valid_i = 1'b0;
      dly = 0;
    end else if (!counter_read_valid_i
                 && counter_read_address_o != skip_addr) begin
      if (dly == 2) begin
        counter_read_valid_i = 1'b1;
        counter_read_data_i  = DW'(counter_read_address_o);
      end else begin
        dly++;
      end
    end
  end

  // Output monitor: stall stability and scoreboard pop
  logic           stall_p = 1'b0;
  logic           busy_p = 1'b0;
  logic [DW-1:0]  h_data;
  logic [TLW-1:0] h_tile;
  logic [RW-1:0]  h_rg;
  logic           h_last;
  logic           h_err;
  always @(negedge noc_clk) begin
    exp_t e;
    if (!rst) begin
      stall_p = 1'b0;
      busy_p  = 1'b0;
    end else begin
      if (busy_o && !busy_p) rise_q.push_back(cyc);
      busy_p = busy_o;
      if (sample_valid_o) begin
        chk("emit_enable_low", counter_read_enable_o, 0);
        if (stall_p) begin
          chk("hold_data", sample_data_o, h_data);
          chk("hold_tile", sample_tile_o, h_tile);
          chk("hold_reg", sample_reg_o, h_rg);
          chk("hold_last", sample_last_o, h_last);
          chk("hold_err", sample_err_o, h_err);
        end
        h_data = sample_data_o;
        h_tile = sample_tile_o;
        h_rg   = sample_reg_o;
        h_last = sample_last_o;
        h_err  = sample_err_o;
        stall_p = !sample_ready_i;
        if (sample_ready_i) begin
          chk("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("s_data", sample_data_o, e.data);
            chk("s_tile", sample_tile_o, e.tile);
            chk("s_reg", sample_reg_o, e.rg);
            chk("s_last", sample_last_o, e.last);
            chk("s_err", sample_err_o, e.err);
          end
        end
      end else begin
        stall_p = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_count(string tag, int target, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge noc_clk);
      if (sweep_count_o == 16'(target)) break;
    end
    chk(tag, sweep_count_o, 64'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int delta;
    int ntot;

    repeat (3) tick();
    @(negedge noc_clk);
    chk("rst_en", counter_read_enable_o, 0);
    chk("rst_addr", counter_read_address_o, 0);
    chk("rst_valid", sample_valid_o, 0);
    chk("rst_data", sample_data_o, 0);
    chk("rst_tile", sample_tile_o, 0);
    chk("rst_reg", sample_reg_o, 0);
    chk("rst_last", sample_last_o, 0);
    chk("rst_err", sample_err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_count", sweep_count_o, 0);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    // basic sweep with fast responder
    push_sweep('1);
    pulse_start();
    wait_count("basic_count", 1, 400);
    tick();
    @(negedge noc_clk);
    chk("basic_busy", busy_o, 0);
    chk("basic_sb", sb.size(), 0);

    // one register never answers
    skip_addr = AW'(16'h0008);
    push_sweep(AW'(16'h0008));
    pulse_start();
    wait_count("to_count", 2, 500);
    chk("to_sb", sb.size(), 0);
    skip_addr = '1;
    tick();

    // backpressure on the first sample
    sample_ready_i = 1'b0;
    push_sweep('1);
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge noc_clk);
      if (sample_valid_o) break;
    end
    chk("bp_valid", sample_valid_o, 1);
    for (int i = 0; i < 50; i++) begin
      tick();
      @(negedge noc_clk);
      chk("bp_en", counter_read_enable_o, 0);
      chk("bp_addr", counter_read_address_o, 0);
      chk("bp_stay", sample_valid_o, 1);
    end
    chk("bp_data", sample_data_o, 0);
    tick();
    sample_ready_i = 1'b1;
    wait_count("bp_count", 3, 400);
    tick();

    // extra start pulses during a sweep coalesce into one
    base = 32'(sweep_count_o);
    push_sweep('1);
    push_sweep('1);
    pulse_start();
    repeat (20) tick();
    pulse_start();
    repeat (10) tick();
    pulse_start();
    repeat (10) tick();
    pulse_start();
    wait_count("co_count", base + 2, 800);
    repeat (100) tick();
    @(negedge noc_clk);
    chk("co_final", sweep_count_o, 64'(base + 2));
    chk("co_busy", busy_o, 0);
    chk("co_sb", sb.size(), 0);

    // periodic sweeps every 200 cycles
    base = 32'(sweep_count_o);
    rise_q.delete();
    repeat (3) push_sweep('1);
    period_i = 32'd200;
    wait_count("per_count", base + 3, 1000);
    period_i = 32'd0;
    repeat (150) tick();
    @(negedge noc_clk);
    chk("per_final", sweep_count_o, 64'(base + 3));
    chk("per_rises", rise_q.size(), 3);
    if (rise_q.size() >= 3) begin
      chk("per_gap1", rise_q[1] - rise_q[0], 200);
      chk("per_gap2", rise_q[2] - rise_q[1], 200);
    end
    chk("per_sb", sb.size(), 0);

    // period shorter than a sweep: back-to-back sweeps
    base = 32'(sweep_count_o);
    repeat (5) push_sweep('1);
    ntot = 5 * (EC + 1) * TC;
    period_i = 32'd30;
    wait_count("short_count", base + 3, 1000);
    period_i = 32'd0;
    repeat (300) tick();
    @(negedge noc_clk);
    delta = 32'(sweep_count_o) - base;
    chk("short_range", (delta == 3) || (delta == 4), 1);
    chk("short_popped", ntot - sb.size(), delta * (EC + 1) * TC);
    chk("short_busy", busy_o, 0);
    sb.delete();

    // reset while a request is outstanding
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      @(negedge noc_clk);
      if (counter_read_enable_o) break;
    end
    chk("mid_en_seen", counter_read_enable_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_en", counter_read_enable_o, 0);
    chk("mid_rst_valid", sample_valid_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    tick();
    rst = 1'b1;
    repeat (20) tick();
    @(negedge noc_clk);
    chk("post_busy", busy_o, 0);
    chk("post_count", sweep_count_o, 0);
    chk("post_valid", sample_valid_o, 0);
    chk("post_en", counter_read_enable_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
